// File: rtl/rtdf_rx_dispatcher_if.sv
// Show-ahead FIFO read port: data and empty flow from the source, and rd_req flows back.
// rd_data is valid while empty=0. A word transfers on any clock edge where rd_req=1 and empty=0.
interface rtdf_rx_dispatcher_if;
  logic [15:0] rd_data;
  logic        empty;
  logic        rd_req;

  modport master (output rd_data, output empty, input rd_req);
  modport slave  (input rd_data, input empty, output rd_req);
endinterface

// File: rtl/rtdf_rx_dispatcher.sv
// Buffers each RX frame's length word and 14-byte header, then classifies the frame by EtherType.
// It then replays the frame to one of two show-ahead consumers, or drops it.
module rtdf_rx_dispatcher #(
  parameter int          LEN_WIDTH   = 11,
  parameter logic [15:0] ETHERTYPE_0 = 16'h88B5,
  parameter logic [15:0] ETHERTYPE_1 = 16'h88B6,
  parameter int          CNT_WIDTH   = 8
) (
  input  logic                 clk_rx,
  input  logic                 reset,
  rtdf_rx_dispatcher_if.slave  rx_fifo,
  rtdf_rx_dispatcher_if.master p0,
  rtdf_rx_dispatcher_if.master p1,
  input  logic                 p0_en,
  input  logic                 p1_en,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] cnt_p0,
  output logic [CNT_WIDTH-1:0] cnt_p1,
  output logic [CNT_WIDTH-1:0] cnt_drop,
  output logic [CNT_WIDTH-1:0] cnt_runt,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {IDLE, RUNT, HDR, DECIDE, REPLAY, PASS, DROP} state_t;

  state_t               state, state_nxt;
  logic [15:0]          hdr_buf [0:7];
  logic [2:0]           idx;
  logic [LEN_WIDTH-1:0] rem;
  logic                 sel;

  logic [LEN_WIDTH:0]   len_sum;
  logic [LEN_WIDTH-1:0] words;
  logic [15:0]          etype;
  logic                 match0, match1, sel_rd_req;
  logic                 rx_pop, port_pop, port_empty;
  logic [15:0]          port_data;
  logic                 inc_p0, inc_p1, inc_drop, inc_runt;

  // Word count is ceil(L/2); one extra bit keeps the +1 from overflowing.
  assign len_sum    = {1'b0, rx_fifo.rd_data[LEN_WIDTH-1:0]} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign words      = len_sum[LEN_WIDTH:1];
  assign etype      = {hdr_buf[7][7:0], hdr_buf[7][15:8]};
  assign match0     = (etype == ETHERTYPE_0) && p0_en;
  assign match1     = (etype == ETHERTYPE_1) && p1_en;
  assign sel_rd_req = sel ? p1.rd_req : p0.rd_req;

  always_comb begin
    state_nxt  = state;
    rx_pop     = 1'b0;
    port_pop   = 1'b0;
    port_empty = 1'b1;
    port_data  = '0;
    inc_p0     = 1'b0;
    inc_p1     = 1'b0;
    inc_drop   = 1'b0;
    inc_runt   = 1'b0;
    case (state)
      IDLE: begin
        rx_pop = !rx_fifo.empty;
        if (rx_pop && words != '0)
          state_nxt = (words < LEN_WIDTH'(7)) ? RUNT : HDR;
      end
      RUNT: begin
        rx_pop = !rx_fifo.empty;
        if (rx_pop && rem == LEN_WIDTH'(1)) begin
          state_nxt = IDLE;
          inc_runt  = 1'b1;
        end
      end
      HDR: begin
        rx_pop = !rx_fifo.empty;
        if (rx_pop && idx == 3'd7) state_nxt = DECIDE;
      end
      DECIDE: begin
        if (match0 || match1) state_nxt = REPLAY;
        else begin
          state_nxt = DROP;
          inc_drop  = 1'b1;
        end
      end
      REPLAY: begin
        port_empty = 1'b0;
        port_data  = hdr_buf[idx];
        port_pop   = sel_rd_req;
        if (port_pop && idx == 3'd7) begin
          if (rem != '0) state_nxt = PASS;
          else begin
            state_nxt = IDLE;
            inc_p0    = !sel;
            inc_p1    = sel;
          end
        end
      end
      PASS: begin
        // Cut-through: the consumer pops the RX FIFO directly.
        port_empty = rx_fifo.empty;
        port_data  = rx_fifo.rd_data;
        port_pop   = sel_rd_req && !rx_fifo.empty;
        rx_pop     = port_pop;
        if (port_pop && rem == LEN_WIDTH'(1)) begin
          state_nxt = IDLE;
          inc_p0    = !sel;
          inc_p1    = sel;
        end
      end
      DROP: begin
        rx_pop = !rx_fifo.empty && rem != '0;
        if (rem == '0 || (rx_pop && rem == LEN_WIDTH'(1))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_fifo.rd_req = rx_pop && !reset;
  assign p0.empty       = sel ? 1'b1 : port_empty;
  assign p0.rd_data     = sel ? '0 : port_data;
  assign p1.empty       = sel ? port_empty : 1'b1;
  assign p1.rd_data     = sel ? port_data : '0;
  assign busy           = (state != IDLE);
  assign state_dbg      = state;

  always_ff @(posedge clk_rx) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      rem      <= '0;
      sel      <= 1'b0;
      cnt_p0   <= '0;
      cnt_p1   <= '0;
      cnt_drop <= '0;
      cnt_runt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (rx_pop) begin
          if (words < LEN_WIDTH'(7)) rem <= words;
          else begin
            rem <= words - LEN_WIDTH'(7);
            idx <= 3'd1;
          end
        end
        // idx wraps 7->0 at the end of HDR, so REPLAY starts at the length word.
        HDR:    if (rx_pop) idx <= idx + 3'd1;
        DECIDE: sel <= !match0;
        REPLAY: if (port_pop) idx <= idx + 3'd1;
        RUNT, PASS, DROP: if (rx_pop) rem <= rem - LEN_WIDTH'(1);
        default: ;
      endcase
      if (inc_p0)   cnt_p0   <= cnt_p0 + CNT_WIDTH'(1);
      if (inc_p1)   cnt_p1   <= cnt_p1 + CNT_WIDTH'(1);
      if (inc_drop) cnt_drop <= cnt_drop + CNT_WIDTH'(1);
      if (inc_runt) cnt_runt <= cnt_runt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_rx) begin
    if (rx_pop && state == IDLE) hdr_buf[0]   <= rx_fifo.rd_data;
    if (rx_pop && state == HDR)  hdr_buf[idx] <= rx_fifo.rd_data;
  end

endmodule

// File: tb/tb_rtdf_rx_dispatcher.sv
// Bench for rtdf_rx_dispatcher: a queue models the upstream show-ahead FIFO.
// A frame-level model predicts each port's word stream and the counters.
module tb_rtdf_rx_dispatcher;
  localparam int          LW = 11;
  localparam int          CW = 8;
  localparam logic [15:0] E0 = 16'h88B5;
  localparam logic [15:0] E1 = 16'h88B6;
  localparam logic [15:0] EX = 16'h0800;

  // clock / reset
  logic clk_rx = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_rx = ~clk_rx;

  rtdf_rx_dispatcher_if rx_fifo ();
  rtdf_rx_dispatcher_if p0 ();
  rtdf_rx_dispatcher_if p1 ();
  logic          p0_en, p1_en, busy;
  logic [CW-1:0] cnt_p0, cnt_p1, cnt_drop, cnt_runt;
  logic [2:0]    state_dbg;

  rtdf_rx_dispatcher dut (
    .clk_rx(clk_rx), .reset(reset), .rx_fifo(rx_fifo), .p0(p0), .p1(p1),
    .p0_en(p0_en), .p1_en(p1_en), .busy(busy),
    .cnt_p0(cnt_p0), .cnt_p1(cnt_p1), .cnt_drop(cnt_drop), .cnt_runt(cnt_runt),
    .state_dbg(state_dbg)
  );

  // scoreboard state
  logic [15:0] rx_q[$];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int m_p0, m_p1, m_drop, m_runt;
  int n_checks, n_fail;
  int rx_gap_pct, p0_req_pct, p1_req_pct;
  int cyc, pop_cnt, viol, p0_show, p1_show, etype_cyc, vis_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame-level reference: decides the fate of a whole frame from L, EtherType and enables
  task automatic push_frame(input logic [15:0] lw, input logic [15:0] et);
    logic [LW-1:0] len;
    logic [15:0]   w16;
    logic [15:0]   frame[$];
    int            w;
    len = lw[LW-1:0];
    w   = (int'(len) + 1) / 2;
    rx_q.push_back(lw);
    for (int i = 0; i < w; i++) begin
      w16 = (i == 6) ? {et[7:0], et[15:8]} : 16'($urandom);
      rx_q.push_back(w16);
      frame.push_back(w16);
    end
    if (w == 0) begin
    end else if (w < 7) m_runt++;
    else if (et == E0 && p0_en) begin
      exp_q0.push_back(lw);
      foreach (frame[i]) exp_q0.push_back(frame[i]);
      m_p0++;
    end else if (et == E1 && p1_en) begin
      exp_q1.push_back(lw);
      foreach (frame[i]) exp_q1.push_back(frame[i]);
      m_p1++;
    end else m_drop++;
  endtask

  // one clock: drive at negedge, sample after settling, account pops before the posedge
  task automatic step();
    @(negedge clk_rx);
    rx_fifo.empty   = (rx_q.size() == 0) || ($urandom_range(99) < rx_gap_pct);
    rx_fifo.rd_data = (rx_q.size() != 0) ? rx_q[0] : 16'hdead;
    p0.rd_req       = ($urandom_range(99) < p0_req_pct);
    p1.rd_req       = ($urandom_range(99) < p1_req_pct);
    #1;
    cyc++;
    if (rx_fifo.rd_req && rx_fifo.empty) viol++;
    if (!p0.empty && !p1.empty) viol++;
    if (!busy && (!p0.empty || !p1.empty || p0.rd_data != 0 || p1.rd_data != 0)) viol++;
    if (!p0.empty) p0_show++;
    if (!p1.empty) p1_show++;
    if (!p0.empty && vis_cyc < 0) vis_cyc = cyc;
    if (p0.rd_req && !p0.empty) begin
      if (exp_q0.size() == 0) check("p0_unexpected_word", {16'h0, p0.rd_data}, 32'hffff_ffff);
      else check("p0_data", {16'h0, p0.rd_data}, {16'h0, exp_q0.pop_front()});
    end
    if (p1.rd_req && !p1.empty) begin
      if (exp_q1.size() == 0) check("p1_unexpected_word", {16'h0, p1.rd_data}, 32'hffff_ffff);
      else check("p1_data", {16'h0, p1.rd_data}, {16'h0, exp_q1.pop_front()});
    end
    if (rx_fifo.rd_req && !rx_fifo.empty) begin
      void'(rx_q.pop_front());
      pop_cnt++;
      if (pop_cnt == 8 && etype_cyc < 0) etype_cyc = cyc;
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (rx_q.size() == 0) && !busy && (exp_q0.size() == 0) && (exp_q1.size() == 0);
    end
    check("drain_done", {31'h0, done}, 32'h1);
  endtask

  task automatic check_state();
    check("cnt_p0", cnt_p0, m_p0[CW-1:0]);
    check("cnt_p1", cnt_p1, m_p1[CW-1:0]);
    check("cnt_drop", cnt_drop, m_drop[CW-1:0]);
    check("cnt_runt", cnt_runt, m_runt[CW-1:0]);
    check("invariants", viol, 0);
  endtask

  initial begin
    int len, pick;
    int lens[4] = '{12, 13, 14, 15};
    n_checks = 0; n_fail = 0; cyc = 0; pop_cnt = 0; viol = 0;
    m_p0 = 0; m_p1 = 0; m_drop = 0; m_runt = 0;
    p0_show = 0; p1_show = 0; etype_cyc = -1; vis_cyc = -1;
    rx_gap_pct = 0; p0_req_pct = 100; p1_req_pct = 100;
    rx_fifo.empty = 1'b1; rx_fifo.rd_data = 16'h0;
    p0.rd_req = 1'b0; p1.rd_req = 1'b0;
    p0_en = 1'b1; p1_en = 1'b1;

    // reset state
    repeat (3) @(posedge clk_rx);
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_busy", busy, 0);
    check("rst_p0_empty", p0.empty, 1);
    check("rst_p1_empty", p1.empty, 1);
    check("rst_p0_data", p0.rd_data, 0);
    check("rst_p1_data", p1.rd_data, 0);
    check("rst_rx_rd_req", rx_fifo.rd_req, 0);
    check_state();
    @(negedge clk_rx);
    reset = 1'b0;

    // L=100 to port 0, continuous, plus header-to-replay latency
    pop_cnt = 0; etype_cyc = -1; vis_cyc = -1; p1_show = 0;
    push_frame(16'd100, E0);
    run_idle(400);
    check("latency", vis_cyc - etype_cyc, 2);
    check("p1_stayed_empty", p1_show, 0);
    check_state();

    // 88B6 with port 1 disabled is dropped unseen, then delivered once enabled
    p1_en = 1'b0; p0_show = 0; p1_show = 0;
    push_frame(16'd64, E1);
    run_idle(400);
    check("drop_p0_show", p0_show, 0);
    check("drop_p1_show", p1_show, 0);
    check_state();
    p1_en = 1'b1;
    push_frame(16'd64, E1);
    run_idle(400);
    check_state();

    // runt then valid frame; then L=0 then valid frame
    push_frame(16'd10, E0);
    push_frame(16'd40, E0);
    run_idle(400);
    check_state();
    pop_cnt = 0;
    push_frame(16'd0, E0);
    push_frame(16'd30, E0);
    run_idle(400);
    check("l0_pops", pop_cnt, 17);
    check_state();

    // boundary word counts around the 7-word header, with an unknown EtherType too
    foreach (lens[i]) begin
      push_frame(16'(lens[i]), E1);
      push_frame(16'(lens[i]), EX);
    end
    run_idle(800);
    check_state();

    // odd L with consumer stalls and a bursty FIFO
    rx_gap_pct = 40; p0_req_pct = 33;
    push_frame(16'd101, E0);
    run_idle(3000);
    check_state();

    // random frames: junk upper bits in the length word, random enables and pacing
    for (int f = 0; f < 12; f++) begin
      len  = $urandom_range(0, 120);
      pick = $urandom_range(0, 2);
      p0_en = 1'($urandom); p1_en = 1'($urandom);
      rx_gap_pct = $urandom_range(0, 50);
      p0_req_pct = $urandom_range(20, 100);
      p1_req_pct = $urandom_range(20, 100);
      push_frame({5'($urandom), 11'(len)}, (pick == 0) ? E0 : (pick == 1) ? E1 : EX);
      run_idle(3000);
      check_state();
    end

    // reset in the middle of a 60-word frame
    p0_en = 1'b1; p1_en = 1'b1; rx_gap_pct = 0; p0_req_pct = 100; p1_req_pct = 100;
    pop_cnt = 0;
    push_frame(16'd120, E0);
    for (int n = 0; n < 300 && pop_cnt < 21; n++) step();
    check("reached_word20", pop_cnt, 21);
    @(negedge clk_rx);
    reset = 1'b1;
    rx_q.delete(); exp_q0.delete(); exp_q1.delete();
    rx_fifo.empty = 1'b1;
    @(posedge clk_rx);
    #1;
    m_p0 = 0; m_p1 = 0; m_drop = 0; m_runt = 0;
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_p0_empty", p0.empty, 1);
    check("mid_rst_p1_empty", p1.empty, 1);
    check_state();
    @(negedge clk_rx);
    reset = 1'b0;
    push_frame(16'd40, E1);
    run_idle(400);
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
